// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-port RAM arbiter.
package ram_arb_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 16;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    ACCESS    = 2'b01,
    READ_WAIT = 2'b10
  } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input picker: a lone requester wins; on a tie the port not served last wins.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       any,
  output logic       pick
);

  always_comb begin
    any  = |req;
    pick = PORT0;
    case (req)
      2'b01:   pick = PORT0;
      2'b10:   pick = PORT1;
      2'b11:   pick = (last == PORT1) ? PORT0 : PORT1;
      default: pick = PORT0;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM (1-cycle read latency).
// Build option: RAM_ARB_FIXED_PRIO_EN makes port 0 win every tie (no round-robin pointer).
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for a request; picks and latches a winner
// ACCESS    | latched request drives the RAM, winner's gnt pulses
// READ_WAIT | RAM output is captured into the winner's rdata
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              Clock,
  input  logic              Resetn,

  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,

  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout
);

  arb_state_t state_q, state_d;

  logic              take;
  logic              win_any;
  logic              win_port;
  logic              last_served;

  logic              lat_we_q;
  logic              lat_port_q;
  logic [ADDR_W-1:0] lat_addr_q;
  logic [DATA_W-1:0] lat_din_q;

  logic              rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  rr_arb2 u_pick (
    .req  ({req1, req0}),
    .last (last_served),
    .any  (win_any),
    .pick (win_port)
  );

`ifdef RAM_ARB_FIXED_PRIO_EN
  assign last_served = PORT1;
`else
  logic last_q;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      last_q <= PORT1;
    end else if (state_q == ACCESS) begin
      last_q <= lat_port_q;
    end
  end

  assign last_served = last_q;
`endif

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_any) begin
          take    = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        state_d = lat_we_q ? IDLE : READ_WAIT;
      end
      READ_WAIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The request latch doubles as the RAM address/data register, so the
  // RAM bus naturally holds its last value outside ACCESS.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      lat_we_q   <= 1'b0;
      lat_port_q <= PORT0;
      lat_addr_q <= '0;
      lat_din_q  <= '0;
    end else if (take) begin
      lat_port_q <= win_port;
      if (win_port == PORT1) begin
        lat_we_q   <= we1;
        lat_addr_q <= addr1;
        lat_din_q  <= wdata1;
      end else begin
        lat_we_q   <= we0;
        lat_addr_q <= addr0;
        lat_din_q  <= wdata0;
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= (state_q == READ_WAIT) && (lat_port_q == PORT0);
      rvalid1_q <= (state_q == READ_WAIT) && (lat_port_q == PORT1);
      if ((state_q == READ_WAIT) && (lat_port_q == PORT0)) begin
        rdata0_q <= mem_dout;
      end
      if ((state_q == READ_WAIT) && (lat_port_q == PORT1)) begin
        rdata1_q <= mem_dout;
      end
    end
  end

  assign gnt0     = (state_q == ACCESS) && (lat_port_q == PORT0);
  assign gnt1     = (state_q == ACCESS) && (lat_port_q == PORT1);
  assign mem_we   = (state_q == ACCESS) && lat_we_q;
  assign mem_addr = lat_addr_q;
  assign mem_din  = lat_din_q;

  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;

endmodule
